// File: rtl/game_pkg.sv
// Shared keyboard/game constants: PS/2 set-2 scan codes, key_press encodings,
// held-bitmap bit indices and the scan-byte decode helpers.
package game_pkg;

  localparam int KEY_W  = 4;
  localparam int HELD_W = 5;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [KEY_W-1:0] KEY_NONE  = 4'd0;
  localparam logic [KEY_W-1:0] KEY_LEFT  = 4'd1;
  localparam logic [KEY_W-1:0] KEY_RIGHT = 4'd2;
  localparam logic [KEY_W-1:0] KEY_DOWN  = 4'd3;
  localparam logic [KEY_W-1:0] KEY_UP    = 4'd4;
  localparam logic [KEY_W-1:0] KEY_FIRE  = 4'd5;

  localparam int HB_UP    = 0;
  localparam int HB_DOWN  = 1;
  localparam int HB_LEFT  = 2;
  localparam int HB_RIGHT = 3;
  localparam int HB_FIRE  = 4;

  typedef struct packed {
    logic              hit;
    logic [HELD_W-1:0] mask;
    logic [2:0]        code;
  } key_dec_t;

  function automatic key_dec_t key_entry(input int bit_idx, input logic [KEY_W-1:0] key);
    key_dec_t d;
    d.hit  = 1'b1;
    d.mask = 5'd1 << bit_idx;
    d.code = key[2:0];
    return d;
  endfunction

  // Extended (E0) and plain codes are separate classes; a code in the wrong class misses.
  function automatic key_dec_t decode_scan(input logic [7:0] sc, input logic ext);
    key_dec_t d;
    d.hit  = 1'b0;
    d.mask = '0;
    d.code = '0;
    if (ext) begin
      case (sc)
        SC_UP:    d = key_entry(HB_UP, KEY_UP);
        SC_DOWN:  d = key_entry(HB_DOWN, KEY_DOWN);
        SC_LEFT:  d = key_entry(HB_LEFT, KEY_LEFT);
        SC_RIGHT: d = key_entry(HB_RIGHT, KEY_RIGHT);
        default:  d.hit = 1'b0;
      endcase
    end else begin
      case (sc)
        SC_W:     d = key_entry(HB_UP, KEY_UP);
        SC_S:     d = key_entry(HB_DOWN, KEY_DOWN);
        SC_A:     d = key_entry(HB_LEFT, KEY_LEFT);
        SC_D:     d = key_entry(HB_RIGHT, KEY_RIGHT);
        SC_SPACE: d = key_entry(HB_FIRE, KEY_FIRE);
        default:  d.hit = 1'b0;
      endcase
    end
    return d;
  endfunction

  function automatic logic [2:0] first_held_code(input logic [HELD_W-1:0] h);
    if (h[HB_UP])    return KEY_UP[2:0];
    if (h[HB_DOWN])  return KEY_DOWN[2:0];
    if (h[HB_LEFT])  return KEY_LEFT[2:0];
    if (h[HB_RIGHT]) return KEY_RIGHT[2:0];
    if (h[HB_FIRE])  return KEY_FIRE[2:0];
    return KEY_NONE[2:0];
  endfunction

endpackage

// File: rtl/key_decoder_if.sv
// PS/2 byte input and decoded key outputs of key_decoder.
interface key_decoder_if;
  import game_pkg::*;

  logic [7:0]        ps2_key_data;
  logic              ps2_key_pressed;
  logic [KEY_W-1:0]  key_press;
  logic [HELD_W-1:0] held;
  logic              key_changed;
  logic              fire;

  modport master (
    output ps2_key_data, ps2_key_pressed,
    input  key_press, held, key_changed, fire
  );

  modport slave (
    input  ps2_key_data, ps2_key_pressed,
    output key_press, held, key_changed, fire
  );
endinterface

// File: rtl/prefix_timer.sv
// Idle timer for a pending prefix: down-counter reloaded by clear, expires at terminal count.
module prefix_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] remain;

  // remain == RELOAD - elapsed, so terminal count 0 means TIMEOUT_CYCLES-1 cycles counted
  always_ff @(posedge CLOCK_50) begin
    if (reset || clear)
      remain <= RELOAD;
    else if (count_en && remain != '0)
      remain <= remain - CW'(1);
  end

  assign expired = count_en && (remain == '0);
endmodule

// File: rtl/key_decoder.sv
// PS/2 set-2 game key decoder: prefix parser FSM plus held bitmap / last-made tracking.
// state   | meaning
// IDLE    | no prefix pending
// EXT     | E0 seen
// BRK     | F0 seen
// EXT_BRK | E0 F0 seen
module key_decoder
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  key_decoder_if.slave kbd
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [HELD_W-1:0] held_q, held_nxt;
  logic [2:0]        last_q, last_nxt;
  logic              changed_q, fire_q;
  logic              tmr_expired;
  logic              is_ext, is_brk;
  logic              do_make, do_break;
  key_dec_t          dec;

  prefix_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_prefix_timer (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clear    (kbd.ps2_key_pressed),
    .count_en (state != ST_IDLE),
    .expired  (tmr_expired)
  );

  assign is_ext = (state == ST_EXT) || (state == ST_EXT_BRK);
  assign is_brk = (state == ST_BRK) || (state == ST_EXT_BRK);
  assign dec    = decode_scan(kbd.ps2_key_data, is_ext);

  // A strobe always wins over a coincident timeout.
  always_comb begin
    state_nxt = state;
    do_make   = 1'b0;
    do_break  = 1'b0;
    if (kbd.ps2_key_pressed) begin
      if (kbd.ps2_key_data == SC_EXT)
        state_nxt = ST_EXT;
      else if (kbd.ps2_key_data == SC_BRK)
        state_nxt = is_ext ? ST_EXT_BRK : ST_BRK;
      else begin
        state_nxt = ST_IDLE;
        do_make   = dec.hit && !is_brk;
        do_break  = dec.hit && is_brk;
      end
    end else if (tmr_expired) begin
      state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    held_nxt = held_q;
    last_nxt = last_q;
    if (do_make && (held_q & dec.mask) == '0) begin
      held_nxt = held_q | dec.mask;
      last_nxt = dec.code;
    end else if (do_break && (held_q & dec.mask) != '0) begin
      held_nxt = held_q & ~dec.mask;
      if (dec.code == last_q)
        last_nxt = first_held_code(held_nxt);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= ST_IDLE;
      held_q    <= '0;
      last_q    <= '0;
      changed_q <= 1'b0;
      fire_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      held_q    <= held_nxt;
      last_q    <= last_nxt;
      changed_q <= (last_nxt != last_q);
      fire_q    <= held_nxt[HB_FIRE] && !held_q[HB_FIRE];
    end
  end

  assign kbd.key_press   = {1'b0, last_q};
  assign kbd.held        = held_q;
  assign kbd.key_changed = changed_q;
  assign kbd.fire        = fire_q;
endmodule

// File: tb/tb_key_decoder.sv
// Directed-vector bench for key_decoder: each byte pushes its hand-computed response,
// a negedge monitor pops and compares the cycle after every accepted strobe.
module tb_key_decoder;
  localparam int TO = 20;

  logic CLOCK_50 = 1'b0;
  logic reset;

  key_decoder_if kbd ();

  key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .kbd      (kbd)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [10:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int spurious = 0;
  int resp_n = 0;
  logic resp_due = 1'b0;

  always @(posedge CLOCK_50) resp_due <= kbd.ps2_key_pressed && !reset;

  always @(negedge CLOCK_50) begin
    logic [10:0] act_v;
    logic [10:0] exp_v;
    act_v = {kbd.key_press, kbd.held, kbd.key_changed, kbd.fire};
    if (resp_due) begin
      checks++;
      resp_n++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp#%0d unexpected response: got kp=%h held=%b ch=%b fire=%b, nothing queued",
                 resp_n, act_v[10:7], act_v[6:2], act_v[1], act_v[0]);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL resp#%0d: got kp=%h held=%b ch=%b fire=%b, want kp=%h held=%b ch=%b fire=%b",
                   resp_n, act_v[10:7], act_v[6:2], act_v[1], act_v[0],
                   exp_v[10:7], exp_v[6:2], exp_v[1], exp_v[0]);
        end
      end
    end else if (kbd.key_changed || kbd.fire) begin
      spurious++;
    end
  end

  task automatic send(input logic [7:0] b, input logic [3:0] kp, input logic [4:0] h,
                      input logic ch, input logic fi);
    @(negedge CLOCK_50);
    exp_q.push_back({kp, h, ch, fi});
    kbd.ps2_key_data    = b;
    kbd.ps2_key_pressed = 1'b1;
    @(negedge CLOCK_50);
    kbd.ps2_key_pressed = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (kbd.key_press !== 4'd0 || kbd.held !== 5'd0 || kbd.key_changed !== 1'b0 || kbd.fire !== 1'b0) begin
      errors++;
      $display("FAIL %s: got kp=%h held=%b ch=%b fire=%b, want all zero",
               tag, kbd.key_press, kbd.held, kbd.key_changed, kbd.fire);
    end
  endtask

  // Reset asserted together with a strobe; the byte must be lost.
  task automatic reset_with_strobe(input logic [7:0] b, input string tag);
    @(negedge CLOCK_50);
    reset               = 1'b1;
    kbd.ps2_key_data    = b;
    kbd.ps2_key_pressed = 1'b1;
    @(negedge CLOCK_50);
    kbd.ps2_key_pressed = 1'b0;
    @(negedge CLOCK_50);
    check_zero(tag);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset               = 1'b1;
    kbd.ps2_key_data    = 8'h00;
    kbd.ps2_key_pressed = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_zero("reset_state");
    reset = 1'b0;

    // single make, then release
    send(8'h1D, 4'd4, 5'b00001, 1, 0);
    send(8'hF0, 4'd4, 5'b00001, 0, 0);
    send(8'h1D, 4'd0, 5'b00000, 1, 0);
    // most recent make wins, release falls back
    send(8'h1D, 4'd4, 5'b00001, 1, 0);
    send(8'h1C, 4'd1, 5'b00101, 1, 0);
    send(8'hF0, 4'd1, 5'b00101, 0, 0);
    send(8'h1C, 4'd4, 5'b00001, 1, 0);
    send(8'hF0, 4'd4, 5'b00001, 0, 0);
    send(8'h1D, 4'd0, 5'b00000, 1, 0);
    // fallback priority and release of a non-active key
    send(8'h23, 4'd2, 5'b01000, 1, 0);
    send(8'h1B, 4'd3, 5'b01010, 1, 0);
    send(8'h1D, 4'd4, 5'b01011, 1, 0);
    send(8'hF0, 4'd4, 5'b01011, 0, 0);
    send(8'h1D, 4'd3, 5'b01010, 1, 0);
    send(8'hF0, 4'd3, 5'b01010, 0, 0);
    send(8'h23, 4'd3, 5'b00010, 0, 0);
    send(8'hF0, 4'd3, 5'b00010, 0, 0);
    send(8'h1B, 4'd0, 5'b00000, 1, 0);
    send(8'hF0, 4'd0, 5'b00000, 0, 0);
    send(8'h1C, 4'd0, 5'b00000, 0, 0);
    // fire with typematic repeat
    send(8'h29, 4'd5, 5'b10000, 1, 1);
    send(8'h29, 4'd5, 5'b10000, 0, 0);
    send(8'h29, 4'd5, 5'b10000, 0, 0);
    send(8'hF0, 4'd5, 5'b10000, 0, 0);
    send(8'h29, 4'd0, 5'b00000, 1, 0);
    send(8'h1D, 4'd4, 5'b00001, 1, 0);
    send(8'h29, 4'd5, 5'b10001, 1, 1);
    send(8'hF0, 4'd5, 5'b10001, 0, 0);
    send(8'h29, 4'd4, 5'b00001, 1, 0);
    send(8'hF0, 4'd4, 5'b00001, 0, 0);
    send(8'h1D, 4'd0, 5'b00000, 1, 0);
    // extended make/break, wrong-class code
    send(8'hE0, 4'd0, 5'b00000, 0, 0);
    send(8'h75, 4'd4, 5'b00001, 1, 0);
    send(8'hE0, 4'd4, 5'b00001, 0, 0);
    send(8'hF0, 4'd4, 5'b00001, 0, 0);
    send(8'h75, 4'd0, 5'b00000, 1, 0);
    send(8'hE0, 4'd0, 5'b00000, 0, 0);
    send(8'h1D, 4'd0, 5'b00000, 0, 0);
    send(8'h1C, 4'd1, 5'b00100, 1, 0);
    send(8'hF0, 4'd1, 5'b00100, 0, 0);
    send(8'h1C, 4'd0, 5'b00000, 1, 0);
    // extended arrows and fallback order
    send(8'hE0, 4'd0, 5'b00000, 0, 0);
    send(8'h72, 4'd3, 5'b00010, 1, 0);
    send(8'hE0, 4'd3, 5'b00010, 0, 0);
    send(8'h6B, 4'd1, 5'b00110, 1, 0);
    send(8'hE0, 4'd1, 5'b00110, 0, 0);
    send(8'h74, 4'd2, 5'b01110, 1, 0);
    send(8'hE0, 4'd2, 5'b01110, 0, 0);
    send(8'hF0, 4'd2, 5'b01110, 0, 0);
    send(8'h74, 4'd3, 5'b00110, 1, 0);
    send(8'hE0, 4'd3, 5'b00110, 0, 0);
    send(8'hF0, 4'd3, 5'b00110, 0, 0);
    send(8'h72, 4'd1, 5'b00100, 1, 0);
    send(8'hE0, 4'd1, 5'b00100, 0, 0);
    send(8'hF0, 4'd1, 5'b00100, 0, 0);
    send(8'h6B, 4'd0, 5'b00000, 1, 0);
    // E0 restarts, repeated F0 ignored, unmapped and wrong-class bytes
    send(8'hF0, 4'd0, 5'b00000, 0, 0);
    send(8'hE0, 4'd0, 5'b00000, 0, 0);
    send(8'h75, 4'd4, 5'b00001, 1, 0);
    send(8'hE0, 4'd4, 5'b00001, 0, 0);
    send(8'hF0, 4'd4, 5'b00001, 0, 0);
    send(8'h1D, 4'd4, 5'b00001, 0, 0);
    send(8'hF0, 4'd4, 5'b00001, 0, 0);
    send(8'hF0, 4'd4, 5'b00001, 0, 0);
    send(8'h1D, 4'd0, 5'b00000, 1, 0);
    send(8'h1A, 4'd0, 5'b00000, 0, 0);
    send(8'hE0, 4'd0, 5'b00000, 0, 0);
    send(8'h29, 4'd0, 5'b00000, 0, 0);
    // timeout boundary: strobe on the expiry cycle is still a break
    send(8'h1B, 4'd3, 5'b00010, 1, 0);
    send(8'hF0, 4'd3, 5'b00010, 0, 0);
    repeat (TO - 2) @(negedge CLOCK_50);
    send(8'h1B, 4'd0, 5'b00000, 1, 0);
    // one cycle later the prefix is gone and the byte is a make
    send(8'hF0, 4'd0, 5'b00000, 0, 0);
    repeat (TO - 1) @(negedge CLOCK_50);
    send(8'h1B, 4'd3, 5'b00010, 1, 0);
    // reset mid-sequence, with a simultaneous strobe
    send(8'h1D, 4'd4, 5'b00011, 1, 0);
    send(8'hE0, 4'd4, 5'b00011, 0, 0);
    reset_with_strobe(8'h1C, "reset_mid_seq");
    send(8'h75, 4'd0, 5'b00000, 0, 0);
    send(8'hF0, 4'd0, 5'b00000, 0, 0);
    send(8'h1D, 4'd0, 5'b00000, 0, 0);

    repeat (3) @(negedge CLOCK_50);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_responses: got %0d left in queue, want 0", exp_q.size());
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL spurious_pulses: got %0d, want 0", spurious);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/key_decoder.md
KEY_DECODER -- requirements
Module: key_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, is the number of idle cycles after which a pending prefix byte is discarded (1 ms at 50 MHz).
REQ-002 CLOCK_50  input  1  system clock; all logic is on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ps2_key_data  input  8  received PS/2 set-2 scan byte; valid only while ps2_key_pressed=1.
REQ-005 ps2_key_pressed  input  1  one-cycle strobe, one per received byte.
REQ-006 key_press  output  4  active key code: 0000 none, 0001 left, 0010 right, 0011 down, 0100 up, 0101 fire.
REQ-007 held  output  5  held-key bitmap: bit0 up, bit1 down, bit2 left, bit3 right, bit4 fire.
REQ-008 key_changed  output  1  one-cycle pulse when key_press takes a new value.
REQ-009 fire  output  1  one-cycle pulse on a fresh fire make.

Function
REQ-010 Key map: W 0x1D and E0 0x75 are up; S 0x1B and E0 0x72 are down; A 0x1C and E0 0x6B are left; D 0x23 and E0 0x74 are right; Space 0x29 is fire.
REQ-011 Parser FSM states are IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-012 Parser transitions on a strobe: IDLE goes to EXT on E0, to BRK on F0, otherwise decodes a make and stays in IDLE.
REQ-013 Parser transitions on a strobe: EXT goes to EXT_BRK on F0, otherwise decodes an extended make and returns to IDLE.
REQ-014 Parser transitions on a strobe: BRK decodes a break and goes to IDLE; EXT_BRK decodes an extended break and goes to IDLE.
REQ-015 An E0 received in EXT, BRK or EXT_BRK restarts the sequence in EXT; an F0 received in BRK or EXT_BRK is ignored and the state is kept.
REQ-016 Unmapped codes, and mapped codes arriving with the wrong prefix class (e.g. E0 1D), change no output and return the parser to IDLE.
REQ-017 A make sets its held bit and a break clears it; a break for a key not held has no effect.
REQ-018 A make for a key already held (typematic repeat) changes nothing and produces no pulse.
REQ-019 key_press is the code of the most recently made key that is still held.
REQ-020 When the active key is released, key_press falls back to the first held key in the order up, down, left, right, fire, or 0000 if none are held.
REQ-021 Latency: held, key_press, key_changed and fire update in the cycle after the strobe carrying the final byte of a sequence.
REQ-022 fire pulses only when bit4 goes from 0 to 1.
REQ-023 key_changed never pulses when the new key_press equals the old value.
REQ-024 A timeout counter clears on every strobe and counts while the parser is not in IDLE.
REQ-025 When the timeout counter reaches TIMEOUT_CYCLES-1, the parser returns to IDLE with no output change.
REQ-026 A strobe arriving in the same cycle as the timeout is processed in the current state, and the strobe wins.
REQ-027 The last-made register is 3 bits wide; the held bitmap and the last-made register are the only key-state storage.

Reset
REQ-028 Reset puts the parser in IDLE, clears the timeout counter, clears the last-made register, drives held=00000 and key_press=0000, and drives key_changed=0 and fire=0.
REQ-029 Reset takes priority over a simultaneous strobe, and that strobe's byte is lost.
REQ-030 A reset asserted mid-sequence (after E0 or F0) discards the prefix.

Structure
REQ-031 Scan-code constants, the key_press encodings, and the held-bit indices live in a shared package (game_pkg), also used by the ship drawing stage.
REQ-032 The timeout counter is a sub-module, prefix_timer, with ports clear, count_en and expired.
REQ-033 The FSM and key-state logic stay in key_decoder.

Verification
REQ-034 Scenario: reset, then byte 1D -> held=00001, key_press=0100, key_changed pulses once, fire=0.
REQ-035 Scenario: bytes 1D, then 1C, then F0 1C -> key_press goes 0100, 0001, 0100, with three key_changed pulses.
REQ-036 Scenario: bytes 29, 29, 29, then F0 29 -> exactly one fire pulse, key_press goes 0101 then 0000, and held bit4 clears.
REQ-037 Scenario: bytes E0 75, then E0 F0 75 -> key_press goes 0100 then 0000; byte E0 1D -> no output change.
REQ-038 Scenario: byte F0, then idle for TIMEOUT_CYCLES, then byte 1B -> 1B is decoded as a make, giving key_press=0011, held=00010.
REQ-039 Scenario: bytes 1D then E0, reset, then F0 1D -> after reset all outputs are 0; the later break changes nothing and key_press stays 0000.
